lfsr_keystream: RTL and testbench

LFSR_KEYSTREAM -- requirements
Module: lfsr_keystream

---
 rtl/lfsr_keystream_pkg.sv | 20 ++
 rtl/lfsr16_step.sv | 17 +
 rtl/lfsr_keystream.sv | 89 ++++++++
 tb/tb_lfsr_keystream.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_keystream_pkg.sv
// Shared constants and FSM encoding for the LFSR keystream generator.
// The zero-seed substitution lives here so every user captures seeds identically.
package lfsr_keystream_pkg;

  localparam int          LFSR_W       = 16;
  localparam logic [15:0] TAP_MASK     = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GEN   = 2'd1,
    ST_VALID = 2'd2
  } state_e;

  // An all-zero seed would lock the LFSR at zero forever.
  function automatic logic [LFSR_W-1:0] fix_seed(input logic [LFSR_W-1:0] s);
    return (s == '0) ? DEFAULT_SEED : s;
  endfunction

endpackage

// File: rtl/lfsr16_step.sv
// One combinational step of the 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1).
// The output bit is the pre-step MSB.
module lfsr16_step
  import lfsr_keystream_pkg::*;
(
  input  logic [LFSR_W-1:0] s_i,
  output logic [LFSR_W-1:0] s_next_o,
  output logic              out_bit_o
);

  logic fb;

  assign fb        = ^(s_i & TAP_MASK);
  assign s_next_o  = {s_i[LFSR_W-2:0], fb};
  assign out_bit_o = s_i[LFSR_W-1];

endmodule

// File: rtl/lfsr_keystream.sv
// Packs N consecutive LFSR output bits (MSB first) into keystream words.
// The LFSR only advances in GEN, so successive words are contiguous in the bit stream.
module lfsr_keystream
  import lfsr_keystream_pkg::*;
#(
  parameter int N = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [LFSR_W-1:0] seed,
  input  logic              ks_ready,
  output logic              ks_valid,
  output logic [N-1:0]      ks,
  output logic              busy,
  output state_e            state_dbg_o
);

  localparam int             CW   = $clog2(N + 1);
  localparam logic [CW-1:0]  LAST = CW'(N - 1);

  state_e            state_q, state_d;
  logic [LFSR_W-1:0] s_q, s_d;
  logic [N-1:0]      ks_q, ks_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [LFSR_W-1:0] s_step;
  logic              out_bit;

  lfsr16_step u_step (
    .s_i       (s_q),
    .s_next_o  (s_step),
    .out_bit_o (out_bit)
  );

  // Handshake: a word transfers on a rising edge with ks_valid && ks_ready;
  // while ks_valid && !ks_ready the word and the LFSR are frozen. load overrides everything.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    ks_d    = ks_q;
    cnt_d   = cnt_q;
    if (load) begin
      state_d = ST_GEN;
      s_d     = fix_seed(seed);
      ks_d    = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
        end
        ST_GEN: begin
          s_d   = s_step;
          ks_d  = N'({ks_q, out_bit});
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST) state_d = ST_VALID;
        end
        ST_VALID: begin
          if (ks_ready) begin
            state_d = ST_GEN;
            ks_d    = '0;
            cnt_d   = '0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      s_q     <= DEFAULT_SEED;
      ks_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      ks_q    <= ks_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decode straight from state so reset clears them without waiting for a clock.
  assign ks_valid    = (state_q == ST_VALID);
  assign busy        = (state_q == ST_GEN);
  assign ks          = ks_q;
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_lfsr_keystream.sv
// Directed bench for lfsr_keystream (N=8): expected words and their arrival cycles
// are queued by the stimulus and checked by a monitor when ks_valid rises.
module tb_lfsr_keystream;
  import lfsr_keystream_pkg::*;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         load;
  logic         ks_ready;
  logic [15:0]  seed;
  logic         ks_valid;
  logic         busy;
  logic [N-1:0] ks;
  state_e       dbg;

  int cyc   = 0;
  int n_cmp = 0;
  int n_err = 0;

  logic [N-1:0] exp_q[$];
  int           exp_cyc_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lfsr_keystream #(.N(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (load),
    .seed        (seed),
    .ks_ready    (ks_ready),
    .ks_valid    (ks_valid),
    .ks          (ks),
    .busy        (busy),
    .state_dbg_o (dbg)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input logic [N-1:0] d, input int c);
    exp_q.push_back(d);
    exp_cyc_q.push_back(c);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) tick(1);
  endtask

  // Returns the edge number at which the seed is captured.
  task automatic load_seed(input logic [15:0] s, output int t);
    t    = cyc + 1;
    load = 1'b1;
    seed = s;
    tick(1);
    load = 1'b0;
  endtask

  task automatic rst_pulse(input string tag);
    rst_n = 1'b0;
    #1;
    chk({tag, "_valid"}, ks_valid, 0);
    chk({tag, "_busy"},  busy,     0);
    chk({tag, "_ks"},    ks,       0);
    chk({tag, "_state"}, dbg,      ST_IDLE);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic monitor();
    logic         prev;
    logic [N-1:0] d;
    int           c;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (ks_valid && !prev) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_word: got %0h expected none (cyc %0d)", ks, cyc);
        end else begin
          d = exp_q.pop_front();
          c = exp_cyc_q.pop_front();
          chk("word_data",  ks,  d);
          chk("word_cycle", cyc, c);
        end
      end
      prev = ks_valid;
    end
  endtask

  initial begin
    int t, t2, x;
    rst_n    = 1'b0;
    load     = 1'b0;
    ks_ready = 1'b0;
    seed     = '0;
    fork
      monitor();
    join_none

    // Reset state, then idle with no load.
    tick(3);
    chk("rst_valid", ks_valid, 0);
    chk("rst_busy",  busy,     0);
    chk("rst_ks",    ks,       0);
    chk("rst_state", dbg,      ST_IDLE);
    rst_n = 1'b1;
    tick(5);
    chk("idle_state", dbg,  ST_IDLE);
    chk("idle_busy",  busy, 0);

    // Streaming with ready held high: AC, E1, E4.
    ks_ready = 1'b1;
    load_seed(16'hACE1, t);
    chk("gen_busy",  busy,     1);
    chk("gen_valid", ks_valid, 0);
    push_exp(8'hAC, t + 8);
    push_exp(8'hE1, t + 17);
    push_exp(8'hE4, t + 26);
    wait_cyc(t + 26);
    ks_ready = 1'b0;
    chk("e4_valid", ks_valid, 1);
    tick(2);
    chk("e4_hold", ks, 8'hE4);

    // Zero seed substitution, loaded from VALID; then a 20-cycle stall.
    load_seed(16'h0000, t);
    chk("reload_valid", ks_valid, 0);
    chk("reload_busy",  busy,     1);
    chk("reload_ks",    ks,       0);
    push_exp(8'hAC, t + 8);
    wait_cyc(t + 8);
    for (int i = 0; i < 20; i++) begin
      tick(1);
      chk("stall_ks",    ks,       8'hAC);
      chk("stall_valid", ks_valid, 1);
      chk("stall_busy",  busy,     0);
    end
    x        = cyc;
    ks_ready = 1'b1;
    push_exp(8'hE1, x + 9);
    tick(1);
    ks_ready = 1'b0;
    chk("hs_valid", ks_valid, 0);
    chk("hs_busy",  busy,     1);
    wait_cyc(x + 9);
    chk("e1_ks", ks, 8'hE1);

    // Reload 3 cycles into GEN: partial word dropped.
    load_seed(16'hACE1, t);
    wait_cyc(t + 3);
    chk("partial_ks", ks, 8'h05);
    load_seed(16'hFFFF, t2);
    chk("abort_valid", ks_valid, 0);
    chk("abort_ks",    ks,       0);
    push_exp(8'hFF, t2 + 8);
    wait_cyc(t2 + 8);
    chk("ff_valid", ks_valid, 1);

    // load and ks_ready on the same edge in VALID: load wins.
    ks_ready = 1'b1;
    load_seed(16'hACE1, t);
    ks_ready = 1'b0;
    push_exp(8'hAC, t + 8);
    wait_cyc(t + 8);
    tick(20);
    chk("collide_ks",    ks,       8'hAC);
    chk("collide_valid", ks_valid, 1);

    // Reset mid-VALID and mid-GEN: nothing emitted afterwards without load.
    rst_pulse("rst_valid");
    tick(5);
    load_seed(16'hACE1, t);
    wait_cyc(t + 3);
    rst_pulse("rst_gen");
    tick(30);
    chk("post_rst_state", dbg,      ST_IDLE);
    chk("post_rst_valid", ks_valid, 0);

    // All-ones seed: FF, FF, then the eight zero feedback bits.
    ks_ready = 1'b1;
    load_seed(16'hFFFF, t);
    push_exp(8'hFF, t + 8);
    push_exp(8'hFF, t + 17);
    push_exp(8'h00, t + 26);
    wait_cyc(t + 26);
    ks_ready = 1'b0;
    tick(3);
    chk("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
